// File: rtl/fu_alu_pipe_if.sv
// ============================================================================
// Module   : fu_alu_pipe_if
// Brief    : Issue-side and result-side handshake bundle for fu_alu_pipe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fu_alu_pipe_if #(
   parameter int XLEN  = 64,
   parameter int ID_W  = 8,
   parameter int PRD_W = 7
);
   logic             flush_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [4:0]       in_op_i;
   logic             in_word_i;
   logic [XLEN-1:0]  in_rs1_i;
   logic [XLEN-1:0]  in_rs2_i;
   logic [XLEN-1:0]  in_pc_i;
   logic [ID_W-1:0]  in_id_i;
   logic [PRD_W-1:0] in_prd_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [XLEN-1:0]  out_pc_o;
   logic [ID_W-1:0]  out_id_o;
   logic [PRD_W-1:0] out_prd_o;
   logic [XLEN-1:0]  out_rdval_o;

   // The functional unit side.
   modport slave (
      input  flush_i, in_valid_i, in_op_i, in_word_i, in_rs1_i, in_rs2_i,
             in_pc_i, in_id_i, in_prd_i, out_ready_i,
      output in_ready_o, out_valid_o, out_pc_o, out_id_o, out_prd_o, out_rdval_o
   );

   // The issue / writeback side.
   modport master (
      output flush_i, in_valid_i, in_op_i, in_word_i, in_rs1_i, in_rs2_i,
             in_pc_i, in_id_i, in_prd_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_pc_o, out_id_o, out_prd_o, out_rdval_o
   );
endinterface

`default_nettype wire

// File: rtl/fu_alu_pipe.sv
// ============================================================================
// Module   : fu_alu_pipe
// Brief    : Pipelined RV32I/RV64I integer ALU functional unit with
//            valid/ready handshake, back-pressure and flush. Optional Zbb
//            subset (ANDN/ORN/XNOR/MIN/MAX/MINU/MAXU) via FU_ALU_PIPE_ZBB_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_alu_pipe #(
   parameter int XLEN   = 64,
   parameter int STAGES = 2,
   parameter int ID_W   = 8,
   parameter int PRD_W  = 7
) (
   input  wire logic    clk,
   input  wire logic    rst,
   fu_alu_pipe_if.slave bus
);

   localparam int         c_SHW      = $clog2(XLEN);
   localparam logic [4:0] c_OP_ADD   = 5'd0;
   localparam logic [4:0] c_OP_SUB   = 5'd1;
   localparam logic [4:0] c_OP_SLL   = 5'd2;
   localparam logic [4:0] c_OP_SLT   = 5'd3;
   localparam logic [4:0] c_OP_SLTU  = 5'd4;
   localparam logic [4:0] c_OP_XOR   = 5'd5;
   localparam logic [4:0] c_OP_SRL   = 5'd6;
   localparam logic [4:0] c_OP_SRA   = 5'd7;
   localparam logic [4:0] c_OP_OR    = 5'd8;
   localparam logic [4:0] c_OP_AND   = 5'd9;
   localparam logic [4:0] c_OP_LUI   = 5'd10;
   localparam logic [4:0] c_OP_AUIPC = 5'd11;
`ifdef FU_ALU_PIPE_ZBB_EN
   localparam logic [4:0] c_OP_ANDN  = 5'd12;
   localparam logic [4:0] c_OP_ORN   = 5'd13;
   localparam logic [4:0] c_OP_XNOR  = 5'd14;
   localparam logic [4:0] c_OP_MIN   = 5'd16;
   localparam logic [4:0] c_OP_MAX   = 5'd17;
   localparam logic [4:0] c_OP_MINU  = 5'd18;
   localparam logic [4:0] c_OP_MAXU  = 5'd19;
`endif

   // ------------------------------------------------------------------------
   // ALU datapath
   // ------------------------------------------------------------------------
   logic [XLEN-1:0]  w_a;
   logic [XLEN-1:0]  w_b;
   logic [XLEN-1:0]  w_sum;
   logic [XLEN:0]    w_diff_ext;
   logic             w_ltu;
   logic             w_lt;
   logic [c_SHW-1:0] w_shamt;
   logic [XLEN-1:0]  w_sll;
   logic [XLEN-1:0]  w_srl;
   logic [XLEN-1:0]  w_sra;
   logic             w_is_word;
   logic [XLEN-1:0]  w_word_res;
   logic [XLEN-1:0]  w_res;

   assign w_a        = bus.in_rs1_i;
   assign w_b        = bus.in_rs2_i;
   assign w_sum      = w_a + w_b;
   // A + ~B + 1: the carry-out is set exactly when A >= B unsigned.
   assign w_diff_ext = {1'b0, w_a} + {1'b0, ~w_b} + {{XLEN{1'b0}}, 1'b1};
   assign w_ltu      = ~w_diff_ext[XLEN];
   assign w_lt       = (w_a[XLEN-1] ^ w_b[XLEN-1]) ? w_a[XLEN-1] : w_ltu;
   assign w_shamt    = w_b[c_SHW-1:0];
   assign w_sll      = w_a << w_shamt;
   assign w_srl      = w_a >> w_shamt;
   assign w_sra      = $signed(w_a) >>> w_shamt;

   generate
      if (XLEN == 64) begin : g_word64
         logic [4:0]  w_sh5;
         logic [31:0] w_sll32;
         logic [31:0] w_srl32;
         logic [31:0] w_sra32;
         logic [31:0] w_res32;

         assign w_sh5   = w_b[4:0];
         assign w_sll32 = w_a[31:0] << w_sh5;
         assign w_srl32 = w_a[31:0] >> w_sh5;
         assign w_sra32 = $signed(w_a[31:0]) >>> w_sh5;

         assign w_is_word = bus.in_word_i &
                            ((bus.in_op_i == c_OP_ADD) | (bus.in_op_i == c_OP_SUB) |
                             (bus.in_op_i == c_OP_SLL) | (bus.in_op_i == c_OP_SRL) |
                             (bus.in_op_i == c_OP_SRA));

         always_comb begin
            w_res32 = w_sum[31:0];
            case (bus.in_op_i)
               c_OP_SUB: w_res32 = w_diff_ext[31:0];
               c_OP_SLL: w_res32 = w_sll32;
               c_OP_SRL: w_res32 = w_srl32;
               c_OP_SRA: w_res32 = w_sra32;
               default:  w_res32 = w_sum[31:0];
            endcase
         end

         assign w_word_res = {{32{w_res32[31]}}, w_res32};
      end else begin : g_word32
         assign w_is_word  = 1'b0;
         assign w_word_res = '0;
      end
   endgenerate

   always_comb begin
      w_res = '0;
      if (w_is_word) begin
         w_res = w_word_res;
      end else begin
         case (bus.in_op_i)
            c_OP_ADD:   w_res = w_sum;
            c_OP_SUB:   w_res = w_diff_ext[XLEN-1:0];
            c_OP_SLL:   w_res = w_sll;
            c_OP_SLT:   w_res = {{(XLEN-1){1'b0}}, w_lt};
            c_OP_SLTU:  w_res = {{(XLEN-1){1'b0}}, w_ltu};
            c_OP_XOR:   w_res = w_a ^ w_b;
            c_OP_SRL:   w_res = w_srl;
            c_OP_SRA:   w_res = w_sra;
            c_OP_OR:    w_res = w_a | w_b;
            c_OP_AND:   w_res = w_a & w_b;
            c_OP_LUI:   w_res = w_sum;
            c_OP_AUIPC: w_res = w_sum;
`ifdef FU_ALU_PIPE_ZBB_EN
            c_OP_ANDN:  w_res = w_a & ~w_b;
            c_OP_ORN:   w_res = w_a | ~w_b;
            c_OP_XNOR:  w_res = ~(w_a ^ w_b);
            c_OP_MIN:   w_res = w_lt  ? w_a : w_b;
            c_OP_MAX:   w_res = w_lt  ? w_b : w_a;
            c_OP_MINU:  w_res = w_ltu ? w_a : w_b;
            c_OP_MAXU:  w_res = w_ltu ? w_b : w_a;
`endif
            default:    w_res = '0;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Result pipeline
   // ------------------------------------------------------------------------
   logic [STAGES-1:0] r_vld;
   logic [STAGES-1:0] w_load;
   logic              w_full_above;
   logic [XLEN-1:0]   r_pc    [STAGES];
   logic [ID_W-1:0]   r_id    [STAGES];
   logic [PRD_W-1:0]  r_prd   [STAGES];
   logic [XLEN-1:0]   r_rdval [STAGES];

   // A stage may load unless it and every stage after it is occupied while
   // the consumer stalls; any bubble downstream lets the stall collapse.
   always_comb begin
      w_load       = '0;
      w_full_above = 1'b1;
      for (int i = STAGES - 1; i >= 0; i--) begin
         w_full_above = w_full_above & r_vld[i];
         w_load[i]    = bus.out_ready_i | ~w_full_above;
      end
   end

   assign bus.in_ready_o = w_load[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld <= '0;
      end else if (bus.flush_i) begin
         r_vld <= '0;
      end else begin
         if (w_load[0]) begin
            r_vld[0] <= bus.in_valid_i;
         end
         for (int i = 1; i < STAGES; i++) begin
            if (w_load[i]) begin
               r_vld[i] <= r_vld[i-1];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_load[0]) begin
         r_pc[0]    <= bus.in_pc_i;
         r_id[0]    <= bus.in_id_i;
         r_prd[0]   <= bus.in_prd_i;
         r_rdval[0] <= w_res;
      end
      for (int i = 1; i < STAGES; i++) begin
         if (w_load[i]) begin
            r_pc[i]    <= r_pc[i-1];
            r_id[i]    <= r_id[i-1];
            r_prd[i]   <= r_prd[i-1];
            r_rdval[i] <= r_rdval[i-1];
         end
      end
   end

   // Payload is not reset, so the outputs are masked to read 0 while empty.
   assign bus.out_valid_o = r_vld[STAGES-1];
   assign bus.out_pc_o    = r_vld[STAGES-1] ? r_pc[STAGES-1]    : '0;
   assign bus.out_id_o    = r_vld[STAGES-1] ? r_id[STAGES-1]    : '0;
   assign bus.out_prd_o   = r_vld[STAGES-1] ? r_prd[STAGES-1]   : '0;
   assign bus.out_rdval_o = r_vld[STAGES-1] ? r_rdval[STAGES-1] : '0;

endmodule

`default_nettype wire

// File: doc/fu_alu_pipe.md
Name: fu_alu_pipe

Overview:
Parametrised, pipelined integer ALU functional unit; successor of the single-cycle combinational ALU FU.
- Sits between the issue stage and writeback/commit.
- Computes RV32I/RV64I ALU ops and W-variants, then carries the result through a configurable register pipeline.
- Uses a valid/ready handshake at both ends, full back-pressure and a global flush.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
STAGES, 2, number of result register stages; legal 1..4.
ID_W, 8, width of the instruction tag.
PRD_W, 7, width of the physical destination register index.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
flush_i  in  1  synchronous kill of all in-flight ops.
in_valid_i  in  1  input op valid.
in_ready_o  out  1  unit can accept an op this cycle.
in_op_i  in  5  opcode (encoding in Behaviour).
in_word_i  in  1  W-variant (32-bit op, sign-extended result); ignored when XLEN=32.
in_rs1_i  in  XLEN  operand A.
in_rs2_i  in  XLEN  operand B or immediate.
in_pc_i  in  XLEN  instruction PC, passed through.
in_id_i  in  ID_W  tag, passed through.
in_prd_i  in  PRD_W  destination, passed through.
out_valid_o  out  1  result valid.
out_ready_i  in  1  consumer accepts the result.
out_pc_o  out  XLEN  PC of the result.
out_id_o  out  ID_W  tag of the result.
out_prd_o  out  PRD_W  destination of the result.
out_rdval_o  out  XLEN  result value.

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI, 11 AUIPC.
  - LUI and AUIPC compute rs1+rs2; the operands are prepared upstream.
  - 12..19 are reserved for the optional feature.
  - Any undefined or disabled opcode produces 0.
- Arithmetic:
  - ADD/SUB: modulo 2^XLEN.
  - SLT: signed compare. SLTU: unsigned compare, taken from the carry-out of A+~B+1. Both return 0 or 1, zero-extended.
  - Shift amount is rs2[log2(XLEN)-1:0]; for word ops it is rs2[4:0].
  - SRA fills with the sign bit.
- in_word_i=1 applies only to ADD, SUB, SLL, SRL, SRA.
  - The op is computed on the low 32 bits; bit 31 is sign-extended to XLEN.
  - SRA word uses bit 31 as the sign; SRL word zero-fills from bit 31.
  - in_word_i is ignored for every other op.
- Pipeline:
  - Result computation is combinational from the in_* ports into stage 0.
  - Stages 0..STAGES-1 each hold valid plus {pc, id, prd, rdval}; out_* are driven from stage STAGES-1.
  - Stage i captures when it is empty or when its own content leaves this cycle (a bubble-collapsing stall).
  - in_ready_o = !v[0] || stage0_advances.
  - Input transfer occurs on in_valid_i && in_ready_o. Output transfer occurs on out_valid_o && out_ready_i.
  - Latency: STAGES cycles from input transfer to out_valid_o when there is no stall.
  - Throughput: 1 op/cycle sustained while out_ready_i=1.
  - Order is strictly preserved; no op is ever dropped or duplicated except by flush.
- While out_valid_o=1 and out_ready_i=0, all out_* are held stable.
- Payload registers do not reset; only valid bits reset.
- Flush:
  - flush_i=1 clears every valid bit at the next edge, including an op transferring in that same cycle, which is discarded.
  - in_ready_o is not gated by flush_i.
  - out_valid_o is 0 in the cycle after the flush.
- Reset: rst=1 immediately clears all valid bits.
  - out_valid_o=0 and in_ready_o=1 while in reset. out_pc_o, out_id_o, out_prd_o and out_rdval_o read 0 after reset until the first op arrives.
  - A reset mid-stall loses all ops; there is no partial state.

Optional Feature:
FU_ALU_PIPE_ZBB_EN.
- Defined: enables 12 ANDN (A&~B), 13 ORN (A|~B), 14 XNOR (~(A^B)), 16 MIN, 17 MAX (signed), 18 MINU, 19 MAXU (unsigned).
  - MIN/MAX reuse the compare logic.
  - Opcode 15 stays reserved and produces 0.
- Undefined: opcodes 12..19 produce 0 and the extra logic is absent.

Test Plan:
1. XLEN=64, STAGES=2, out_ready=1: ADD 0x7FFFFFFFFFFFFFFF+1 -> 0x8000000000000000 exactly 2 cycles later; ADDW 0x7FFFFFFF+1 -> 0xFFFFFFFF80000000.
2. SRA 0x8000000000000000 by 63 -> 0xFFFFFFFFFFFFFFFF; SRAW 0x80000000 by 31 -> all-ones; SLLW 1 by 31 -> 0xFFFFFFFF80000000; SRLW 0xFFFFFFFF by 4 -> 0x000000000FFFFFFF.
3. SLT(-1,1) -> 1, SLTU(-1,1) -> 0, SLT(5,5) -> 0, SUB 0-1 -> all-ones.
4. Back-to-back issue of 6 ops with out_ready low for 3 cycles mid-stream:
   - in_ready drops once both stages are full.
   - All 6 results emerge in order with ids 0..5.
   - Outputs stay stable during the stall.
5. Flush with 2 ops in flight and a third transferring in the same cycle -> no out_valid for any of the three; the next op issued returns normally after 2 cycles.
6. With FU_ALU_PIPE_ZBB_EN: MIN(-3,2) -> -3, MINU(-3,2) -> 2, ANDN(0xF0,0xFF) -> 0. Without the macro, opcode 16 -> 0. Assert rst mid-stall -> out_valid=0 and in_ready=1 immediately.
